step_ctrl: RTL and testbench

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/step_ctrl.sv | 142 ++++++++++++++
 tb/tb_step_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// Step/run clock-enable controller: gates N_CH channel enables for single steps,
// counted runs or free runs, and stops on count, STOP command or halt.
module step_ctrl #(
  parameter int CNT_W = 16,
  parameter int N_CH  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [N_CH-1:0]  cmd_mask,
  input  logic             halt,
  output logic [N_CH-1:0]  ce,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_reason,
  output logic             cmd_err,
  output logic [CNT_W-1:0] cycles_run
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FREE = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_STOP  = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_RUN_N = 2'd2;
  localparam logic [1:0] OP_FREE  = 2'd3;

  localparam logic [1:0] R_COUNT = 2'd0;
  localparam logic [1:0] R_STOP  = 2'd1;
  localparam logic [1:0] R_HALT  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [N_CH-1:0]  ce_d;
  logic [1:0]       reason_d;
  logic             err_d;
  logic             clear_cycles;
  logic             xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign cmd_ready = (state_q != S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign xfer      = cmd_valid && cmd_ready;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    mask_d       = mask_q;
    reason_d     = R_COUNT;
    err_d        = 1'b0;
    clear_cycles = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          case (cmd_op)
            OP_STEP: begin
              state_d      = S_RUN;
              remaining_d  = CNT_ONE;
              mask_d       = cmd_mask;
              clear_cycles = 1'b1;
            end
            OP_RUN_N: begin
              clear_cycles = 1'b1;
              if (cmd_count != '0) begin
                state_d     = S_RUN;
                remaining_d = cmd_count;
                mask_d      = cmd_mask;
              end else begin
                state_d  = S_DONE;
                reason_d = R_COUNT;
              end
            end
            OP_FREE: begin
              state_d      = S_FREE;
              mask_d       = cmd_mask;
              clear_cycles = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_RUN, S_FREE: begin
        // Only STOP is meaningful while running; anything else is flagged and dropped.
        err_d = xfer && (cmd_op != OP_STOP);
        if (state_q == S_RUN)
          remaining_d = remaining_q - CNT_ONE;
        if (halt) begin
          state_d  = S_DONE;
          reason_d = R_HALT;
        end else if (xfer && (cmd_op == OP_STOP)) begin
          state_d  = S_DONE;
          reason_d = R_STOP;
        end else if ((state_q == S_RUN) && (remaining_q == CNT_ONE)) begin
          state_d  = S_DONE;
          reason_d = R_COUNT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ce_d = ((state_d == S_RUN) || (state_d == S_FREE)) ? mask_d : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      mask_q      <= '0;
      ce          <= '0;
      done_reason <= R_COUNT;
      cmd_err     <= 1'b0;
      cycles_run  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      mask_q      <= mask_d;
      ce          <= ce_d;
      done_reason <= reason_d;
      cmd_err     <= err_d;
      // A start command only comes from IDLE where ce is 0, so clear never races an increment.
      if (clear_cycles)
        cycles_run <= '0;
      else if (|ce)
        cycles_run <= sat_inc(cycles_run);
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed testbench for step_ctrl: a default-width instance plus a CNT_W=4
// instance for saturation and maximum-count behaviour.
module tb_step_ctrl;
  localparam int CNT_W = 16;
  localparam int N_CH  = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [N_CH-1:0]  cmd_mask = '0;
  logic             halt = 1'b0;
  logic [N_CH-1:0]  ce;
  logic             busy, done, cmd_err;
  logic [1:0]       done_reason;
  logic [CNT_W-1:0] cycles_run;

  logic             cmd_valid4 = 1'b0;
  logic             cmd_ready4;
  logic [1:0]       cmd_op4 = 2'd0;
  logic [3:0]       cmd_count4 = '0;
  logic [N_CH-1:0]  cmd_mask4 = '0;
  logic             halt4 = 1'b0;
  logic [N_CH-1:0]  ce4;
  logic             busy4, done4, cmd_err4;
  logic [1:0]       done_reason4;
  logic [3:0]       cycles_run4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  step_ctrl #(.CNT_W(CNT_W), .N_CH(N_CH)) u_dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_mask(cmd_mask), .halt(halt),
    .ce(ce), .busy(busy), .done(done), .done_reason(done_reason),
    .cmd_err(cmd_err), .cycles_run(cycles_run)
  );

  step_ctrl #(.CNT_W(4), .N_CH(N_CH)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op4), .cmd_count(cmd_count4), .cmd_mask(cmd_mask4), .halt(halt4),
    .ce(ce4), .busy(busy4), .done(done4), .done_reason(done_reason4),
    .cmd_err(cmd_err4), .cycles_run(cycles_run4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] cnt, input logic [N_CH-1:0] m);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_mask = m;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic issue4(input logic [1:0] op, input logic [3:0] cnt, input logic [N_CH-1:0] m);
    cmd_valid4 = 1'b1; cmd_op4 = op; cmd_count4 = cnt; cmd_mask4 = m;
    tick();
    cmd_valid4 = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ce !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || done_reason !== 2'd0 ||
        cmd_err !== 1'b0 || cycles_run !== 16'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: ce=%b busy=%b done=%b reason=%0d err=%b cycles=%0d ready=%b, expected 0000 0 0 0 0 0 1",
               ce, busy, done, done_reason, cmd_err, cycles_run, cmd_ready);
    end
    checks++;
    if (ce4 !== 4'b0000 || busy4 !== 1'b0 || cycles_run4 !== 4'd0 || cmd_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_values4: ce=%b busy=%b cycles=%0d ready=%b, expected 0000 0 0 1", ce4, busy4, cycles_run4, cmd_ready4);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_run_n();
    issue(2'd2, 16'd3, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ce !== 4'b0101 || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL run_n_active[%0d]: ce=%b done=%b busy=%b, expected 0101 0 1", i, ce, done, busy);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || done_reason !== 2'd0 || ce !== 4'b0000 || cycles_run !== 16'd3 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_n_done: done=%b reason=%0d ce=%b cycles=%0d ready=%b busy=%b, expected 1 0 0000 3 0 1",
               done, done_reason, ce, cycles_run, cmd_ready, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cycles_run !== 16'd3 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_n_idle: busy=%b done=%b cycles=%0d ready=%b, expected 0 0 3 1", busy, done, cycles_run, cmd_ready);
    end
  endtask

  task automatic test_step_and_zero();
    issue(2'd1, 16'd0, 4'b1111);
    checks++;
    if (ce !== 4'b1111 || cycles_run !== 16'd0) begin
      errors++;
      $display("FAIL step_active: ce=%b cycles=%0d, expected 1111 0", ce, cycles_run);
    end
    tick();
    checks++;
    if (done !== 1'b1 || done_reason !== 2'd0 || ce !== 4'b0000 || cycles_run !== 16'd1) begin
      errors++;
      $display("FAIL step_done: done=%b reason=%0d ce=%b cycles=%0d, expected 1 0 0000 1", done, done_reason, ce, cycles_run);
    end
    tick();
    issue(2'd2, 16'd0, 4'b1111);
    checks++;
    if (done !== 1'b1 || done_reason !== 2'd0 || ce !== 4'b0000 || cycles_run !== 16'd0) begin
      errors++;
      $display("FAIL run_zero_done: done=%b reason=%0d ce=%b cycles=%0d, expected 1 0 0000 0", done, done_reason, ce, cycles_run);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL run_zero_idle: busy=%b done=%b, expected 0 0", busy, done);
    end
    issue(2'd2, 16'd2, 4'b0000);
    checks++;
    if (busy !== 1'b1 || ce !== 4'b0000 || done !== 1'b0) begin
      errors++;
      $display("FAIL mask0_active: busy=%b ce=%b done=%b, expected 1 0000 0", busy, ce, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mask0_second: done=%b busy=%b, expected 0 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || done_reason !== 2'd0 || cycles_run !== 16'd0) begin
      errors++;
      $display("FAIL mask0_done: done=%b reason=%0d cycles=%0d, expected 1 0 0", done, done_reason, cycles_run);
    end
    tick();
  endtask

  task automatic test_free_stop();
    issue(2'd3, 16'd0, 4'b0001);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (ce !== 4'b0001 || busy !== 1'b1 || cycles_run !== 16'd10) begin
      errors++;
      $display("FAIL free_running: ce=%b busy=%b cycles=%0d, expected 0001 1 10", ce, busy, cycles_run);
    end
    issue(2'd0, 16'd0, 4'b0000);
    checks++;
    if (done !== 1'b1 || done_reason !== 2'd1 || ce !== 4'b0000 || cycles_run !== 16'd11 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL free_stop_done: done=%b reason=%0d ce=%b cycles=%0d err=%b, expected 1 1 0000 11 0",
               done, done_reason, ce, cycles_run, cmd_err);
    end
    tick();
    // STOP and halt sampled on the same edge
    issue(2'd3, 16'd0, 4'b0011);
    tick();
    tick();
    halt = 1'b1;
    issue(2'd0, 16'd0, 4'b0000);
    halt = 1'b0;
    checks++;
    if (done !== 1'b1 || done_reason !== 2'd2) begin
      errors++;
      $display("FAIL stop_halt_priority: done=%b reason=%0d, expected 1 2", done, done_reason);
    end
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL halt_in_idle: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_halt();
    issue(2'd2, 16'd100, 4'b1010);
    for (int i = 0; i < 4; i++) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++;
    if (done !== 1'b1 || done_reason !== 2'd2 || ce !== 4'b0000 || cycles_run !== 16'd5) begin
      errors++;
      $display("FAIL halt_done: done=%b reason=%0d ce=%b cycles=%0d, expected 1 2 0000 5", done, done_reason, ce, cycles_run);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_back_to_back_err();
    issue(2'd2, 16'd4, 4'b0110);
    tick();
    issue(2'd2, 16'd9, 4'b1111);
    checks++;
    if (cmd_err !== 1'b1 || ce !== 4'b0110 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: err=%b ce=%b busy=%b, expected 1 0110 1", cmd_err, ce, busy);
    end
    tick();
    checks++;
    if (cmd_err !== 1'b0 || ce !== 4'b0110 || done !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle: err=%b ce=%b done=%b, expected 0 0110 0", cmd_err, ce, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || done_reason !== 2'd0 || cycles_run !== 16'd4) begin
      errors++;
      $display("FAIL err_run_done: done=%b reason=%0d cycles=%0d, expected 1 0 4", done, done_reason, cycles_run);
    end
    tick();
    issue(2'd0, 16'd0, 4'b0000);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_stop: busy=%b done=%b err=%b, expected 0 0 0", busy, done, cmd_err);
    end
  endtask

  task automatic test_saturate();
    int n;
    issue4(2'd3, 4'd0, 4'b0001);
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (cycles_run4 !== 4'd14) begin
      errors++;
      $display("FAIL sat_pre: cycles=%0d, expected 14", cycles_run4);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (cycles_run4 !== 4'd15 || ce4 !== 4'b0001 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: cycles=%0d ce=%b busy=%b, expected 15 0001 1", cycles_run4, ce4, busy4);
    end
    issue4(2'd0, 4'd0, 4'b0000);
    checks++;
    if (done4 !== 1'b1 || done_reason4 !== 2'd1 || cycles_run4 !== 4'd15) begin
      errors++;
      $display("FAIL sat_stop: done=%b reason=%0d cycles=%0d, expected 1 1 15", done4, done_reason4, cycles_run4);
    end
    tick();
    issue4(2'd2, 4'd15, 4'b1001);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done4 === 1'b1) break;
      if (ce4 !== 4'b0000) n++;
      tick();
    end
    checks++;
    if (done4 !== 1'b1 || n != 15 || cycles_run4 !== 4'd15 || done_reason4 !== 2'd0) begin
      errors++;
      $display("FAIL max_count: done=%b ce_cycles=%0d cycles=%0d reason=%0d, expected 1 15 15 0", done4, n, cycles_run4, done_reason4);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    issue(2'd2, 16'd10, 4'b1111);
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ce !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || done_reason !== 2'd0 ||
        cmd_err !== 1'b0 || cycles_run !== 16'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run: ce=%b busy=%b done=%b reason=%0d err=%b cycles=%0d ready=%b, expected 0000 0 0 0 0 0 1",
               ce, busy, done, done_reason, cmd_err, cycles_run, cmd_ready);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: done=%b busy=%b, expected 0 0", done, busy);
    end
    #2 reset_n = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ce !== 4'b0000) begin
      errors++;
      $display("FAIL reset_after_release: done=%b busy=%b ce=%b, expected 0 0 0000", done, busy, ce);
    end
    issue(2'd2, 16'd2, 4'b0011);
    checks++;
    if (ce !== 4'b0011 || busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_run: ce=%b busy=%b, expected 0011 1", ce, busy);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || done_reason !== 2'd0 || cycles_run !== 16'd2) begin
      errors++;
      $display("FAIL post_reset_done: done=%b reason=%0d cycles=%0d, expected 1 0 2", done, done_reason, cycles_run);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b, expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_run_n();
    test_step_and_zero();
    test_free_stop();
    test_halt();
    test_back_to_back_err();
    test_saturate();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
